// File: rtl/floo_sim_ctrl.sv
// -----------------------------------------------------------------------------
// floo_sim_ctrl
//
// Simulation run controller. It generates a multi-pulse active-low reset for
// the device under test, then periodically polls a set of exit-status channels
// until every channel has reported completion. An optional watchdog ends the
// run if it takes too long. The final status is presented as done/fail/timeout
// flags and an exit code.
//
// Ports
//   clk_i        in   1              clock, rising edge
//   rst_ni       in   1              asynchronous active-low reset
//   sys_rst_no   out  1              generated active-low reset for the DUT
//   poll_req_o   out  1              poll request valid
//   poll_ch_o    out  ChW            channel being polled
//   poll_ack_i   in   1              poll response valid (used only while polling)
//   poll_data_i  in   DataWidth      0 = running, else finished; [DW-1:1] = code
//   done_o       out  1              run finished (sticky until rst_ni)
//   fail_o       out  1              run finished with timeout or nonzero code
//   timeout_o    out  1              watchdog expired (sticky until rst_ni)
//   exit_code_o  out  DataWidth-1    code of lowest-index channel with nonzero code
//
// States
//   state  | meaning
//   RST_LO | sys_rst_no low, counting ResetCycles
//   RST_HI | sys_rst_no high, counting ResetCycles; loops or proceeds to WAIT
//   WAIT   | idle for PollInterval cycles between polls
//   POLL   | poll_req_o high, holding channel until poll_ack_i
//   DONE   | all channels finished or watchdog expired; left only by rst_ni
// -----------------------------------------------------------------------------
module floo_sim_ctrl #(
  parameter int unsigned NumChannels   = 1,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned ResetPulses   = 2,
  parameter int unsigned ResetCycles   = 10,
  parameter int unsigned PollInterval  = 200,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                                               clk_i,
  input  logic                                               rst_ni,
  output logic                                               sys_rst_no,
  output logic                                               poll_req_o,
  output logic [((NumChannels > 1) ? $clog2(NumChannels) : 1)-1:0] poll_ch_o,
  input  logic                                               poll_ack_i,
  input  logic [DataWidth-1:0]                               poll_data_i,
  output logic                                               done_o,
  output logic                                               fail_o,
  output logic                                               timeout_o,
  output logic [DataWidth-2:0]                               exit_code_o
);

  localparam int unsigned ChW     = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned CntMax  = (ResetCycles > PollInterval) ? ResetCycles : PollInterval;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned PulseW  = $clog2(ResetPulses + 1);
  localparam int unsigned WdW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned CodeW   = DataWidth - 1;

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    WAIT,
    POLL,
    DONE
  } state_e;

  state_e                 r_state, w_state_nxt;
  logic [CntW-1:0]        r_cnt, w_cnt_nxt;
  logic [PulseW-1:0]      r_pulse, w_pulse_nxt;
  logic [WdW-1:0]         r_wdog, w_wdog_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic [ChW-1:0]         r_ch, w_ch_nxt;
  logic [NumChannels-1:0] r_fin, w_fin_nxt;
  logic [CodeW-1:0]       r_code     [NumChannels];
  logic [CodeW-1:0]       w_code_nxt [NumChannels];

  logic                   w_hs;
  logic                   w_data_nz;
  logic                   w_expire;
  logic                   w_all_fin;
  logic [NumChannels-1:0] w_fin_upd;
  logic [ChW-1:0]         w_ch_rr;
  logic [CodeW-1:0]       w_exit;
  logic                   w_any_code;
  logic                   w_run;

  // ---------------------------------------------------------------------------
  // Handshake bookkeeping: finished-flag update and round-robin pointer
  // ---------------------------------------------------------------------------
  assign w_hs      = (r_state == POLL) && poll_ack_i;
  assign w_data_nz = |poll_data_i;
  assign w_run     = (r_state == WAIT) || (r_state == POLL);

  always_comb begin
    w_fin_upd = r_fin;
    for (int j = 0; j < int'(NumChannels); j++) begin
      if (w_hs && w_data_nz && (ChW'(j) == r_ch)) begin
        w_fin_upd[j] = 1'b1;
      end
    end
  end

  assign w_all_fin = &w_fin_upd;

  // Next unfinished channel after the current one. Distance is measured
  // forward with wrap, so the current channel itself has the largest distance
  // and is chosen only when it is the sole unfinished channel.
  always_comb begin : rr_pick
    int w_dist;
    int w_best;
    w_ch_rr = r_ch;
    w_best  = int'(NumChannels) + 1;
    w_dist  = 0;
    for (int j = 0; j < int'(NumChannels); j++) begin
      if (!w_fin_upd[j]) begin
        w_dist = j - int'(r_ch);
        if (w_dist <= 0) begin
          w_dist = w_dist + int'(NumChannels);
        end
        if (w_dist < w_best) begin
          w_best  = w_dist;
          w_ch_rr = ChW'(j);
        end
      end
    end
  end

  // Watchdog expires on the TimeoutCycles-th counted WAIT/POLL cycle.
  always_comb begin
    w_expire = 1'b0;
    if (TimeoutCycles != 0) begin
      w_expire = w_run && (r_wdog == WdW'(TimeoutCycles - 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = r_pulse;
    w_wdog_nxt    = r_wdog;
    w_timeout_nxt = r_timeout;
    w_ch_nxt      = r_ch;
    w_fin_nxt     = r_fin;
    w_code_nxt    = r_code;

    case (r_state)
      RST_LO: begin
        if (r_cnt == CntW'(ResetCycles - 1)) begin
          w_cnt_nxt   = '0;
          w_pulse_nxt = r_pulse + PulseW'(1);
          w_state_nxt = RST_HI;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      RST_HI: begin
        if (r_cnt == CntW'(ResetCycles - 1)) begin
          w_cnt_nxt = '0;
          if (r_pulse == PulseW'(ResetPulses)) begin
            w_state_nxt = WAIT;
          end else begin
            w_state_nxt = RST_LO;
          end
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      WAIT: begin
        if (r_cnt == CntW'(PollInterval - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = POLL;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      POLL: begin
        if (w_hs) begin
          w_fin_nxt = w_fin_upd;
          for (int j = 0; j < int'(NumChannels); j++) begin
            if (w_data_nz && (ChW'(j) == r_ch)) begin
              w_code_nxt[j] = poll_data_i[DataWidth-1:1];
            end
          end
          w_ch_nxt    = w_ch_rr;
          w_cnt_nxt   = '0;
          w_state_nxt = w_all_fin ? DONE : WAIT;
        end
      end

      DONE: begin
        w_state_nxt = DONE;
      end

      default: begin
        w_state_nxt = RST_LO;
      end
    endcase

    // Watchdog overrides the handshake outcome but keeps its recorded data.
    if ((TimeoutCycles != 0) && w_run) begin
      if (w_expire) begin
        w_state_nxt   = DONE;
        w_timeout_nxt = 1'b1;
      end else begin
        w_wdog_nxt = r_wdog + WdW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= RST_LO;
      r_cnt     <= '0;
      r_pulse   <= '0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
      r_ch      <= '0;
      r_fin     <= '0;
      for (int j = 0; j < int'(NumChannels); j++) begin
        r_code[j] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_wdog    <= w_wdog_nxt;
      r_timeout <= w_timeout_nxt;
      r_ch      <= w_ch_nxt;
      r_fin     <= w_fin_nxt;
      for (int j = 0; j < int'(NumChannels); j++) begin
        r_code[j] <= w_code_nxt[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  // Codes of unfinished channels stay zero, so scanning codes alone finds the
  // lowest-index finished channel with a nonzero code.
  always_comb begin
    w_exit     = '0;
    w_any_code = 1'b0;
    for (int j = int'(NumChannels) - 1; j >= 0; j--) begin
      if (r_code[j] != '0) begin
        w_exit     = r_code[j];
        w_any_code = 1'b1;
      end
    end
  end

  assign sys_rst_no  = (r_state != RST_LO);
  assign poll_req_o  = (r_state == POLL);
  assign poll_ch_o   = r_ch;
  assign done_o      = (r_state == DONE);
  assign timeout_o   = r_timeout;
  assign exit_code_o = done_o ? w_exit : '0;
  assign fail_o      = done_o && (r_timeout || w_any_code);

endmodule
